// File: rtl/gol_gen_sequencer.sv
// rtl/gol_gen_sequencer.sv - Game of Life single-generation ping-pong sequencer
module gol_gen_sequencer #(
  parameter int FIELD_W    = 64,
  parameter int FIELD_H    = 48,
  parameter int RD_LATENCY = 1,
  parameter int GEN_CNT_W  = 16,
  parameter int X_W        = $clog2(FIELD_W),
  parameter int Y_W        = $clog2(FIELD_H),
  parameter int POP_W      = $clog2(FIELD_W*FIELD_H+1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_run,
  input  logic                 i_step,
  input  logic [8:0]           i_birth_mask,
  input  logic [8:0]           i_survive_mask,
  output logic [X_W-1:0]       o_rd_x,
  output logic [Y_W-1:0]       o_rd_y,
  input  logic                 i_cell_state,
  input  logic [3:0]           i_nbrs_cnt,
  output logic [X_W-1:0]       o_wr_x,
  output logic [Y_W-1:0]       o_wr_y,
  output logic                 o_wr_data,
  output logic                 o_wr_en_a,
  output logic                 o_wr_en_b,
  output logic                 o_read_field,
  output logic                 o_busy,
  output logic                 o_gen_done,
  output logic [GEN_CNT_W-1:0] o_gen_cnt,
  output logic [POP_W-1:0]     o_pop_cnt
);

  localparam logic [X_W-1:0] X_MAX = X_W'(FIELD_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(FIELD_H - 1);
  localparam int DC_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(RD_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_DRAIN,
    S_SWAP
  } state_t;

  state_t state, state_nxt;

  logic            start;
  logic            issue;
  logic            last_addr;
  logic            drain_last;
  logic [DC_W-1:0] drain_cnt;
  logic [8:0]      birth_q;
  logic [8:0]      survive_q;
  logic [POP_W-1:0] pop_acc;

  logic [RD_LATENCY-1:0] vld_pipe;
  logic [X_W-1:0]        x_pipe [RD_LATENCY];
  logic [Y_W-1:0]        y_pipe [RD_LATENCY];

  logic wr_valid;
  logic rule_bit;

  assign last_addr  = (o_rd_x == X_MAX) && (o_rd_y == Y_MAX);
  assign drain_last = (drain_cnt == DRAIN_LAST);
  assign o_busy     = (state != S_IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; start and issue strobes derived from the current state
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    issue     = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_run || i_step) begin
          start     = 1'b1;
          state_nxt = S_SWEEP;
        end
      end
      S_SWEEP: begin
        issue = 1'b1;
        if (last_addr) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_last) state_nxt = S_SWAP;
      end
      S_SWAP: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Raster read address; parks on the last cell until the next start
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_rd_x <= '0;
      o_rd_y <= '0;
    end else if (start) begin
      o_rd_x <= '0;
      o_rd_y <= '0;
    end else if (issue && !last_addr) begin
      if (o_rd_x == X_MAX) begin
        o_rd_x <= '0;
        o_rd_y <= o_rd_y + Y_W'(1);
      end else begin
        o_rd_x <= o_rd_x + X_W'(1);
      end
    end
  end

  // Rule masks are frozen for the whole generation at start
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      birth_q   <= '0;
      survive_q <= '0;
    end else if (start) begin
      birth_q   <= i_birth_mask;
      survive_q <= i_survive_mask;
    end
  end

  // Drain cycle counter, held at zero outside DRAIN
  always_ff @(posedge clk) begin
    if (!rst_n)                drain_cnt <= '0;
    else if (state == S_DRAIN) drain_cnt <= drain_cnt + DC_W'(1);
    else                       drain_cnt <= '0;
  end

  // Valid/address shadow matching the RAM read latency
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        x_pipe[i] <= '0;
        y_pipe[i] <= '0;
      end
    end else begin
      vld_pipe[0] <= issue;
      x_pipe[0]   <= o_rd_x;
      y_pipe[0]   <= o_rd_y;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        x_pipe[i]   <= x_pipe[i-1];
        y_pipe[i]   <= y_pipe[i-1];
      end
    end
  end

  assign wr_valid = vld_pipe[RD_LATENCY-1];

  // Birth/survive lookup; counts above 8 never set a cell
  always_comb begin
    rule_bit = 1'b0;
    if (i_nbrs_cnt <= 4'd8) begin
      rule_bit = i_cell_state ? survive_q[i_nbrs_cnt] : birth_q[i_nbrs_cnt];
    end
  end

  assign o_wr_data = wr_valid & rule_bit;
  assign o_wr_x    = wr_valid ? x_pipe[RD_LATENCY-1] : '0;
  assign o_wr_y    = wr_valid ? y_pipe[RD_LATENCY-1] : '0;
  assign o_wr_en_a = wr_valid &  o_read_field;
  assign o_wr_en_b = wr_valid & ~o_read_field;

  // Generation bookkeeping: field swap, counters and completion pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_read_field <= 1'b0;
      o_gen_cnt    <= '0;
      o_pop_cnt    <= '0;
      pop_acc      <= '0;
      o_gen_done   <= 1'b0;
    end else begin
      o_gen_done <= (state == S_SWAP);
      if (state == S_SWAP) begin
        o_read_field <= ~o_read_field;
        o_gen_cnt    <= o_gen_cnt + GEN_CNT_W'(1);
        o_pop_cnt    <= pop_acc;
        pop_acc      <= '0;
      end else if (o_wr_data) begin
        pop_acc <= pop_acc + POP_W'(1);
      end
    end
  end

endmodule
